pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed ID/EX latch. It carries an arbitrary packed payload between two pipeline stages using a valid/ready handshake rather than a bare enable. It provides a synchronous flush that injects a NOP, optional bubble clearing, an optional skid entry for a registered `in_ready`, and a saturating stall counter. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit's flush and by the downstream stage's ready.

## Interface
- DATA_W, 32: payload width in bits; any value ≥ 1.
- CLEAR_VALUE, '0: payload value representing a NOP/bubble; loaded on reset, flush and (optionally) drain.
- BUBBLE_CLEAR, 1: 1 = `out_data` forced to CLEAR_VALUE whenever the entry empties; 0 = `out_data` holds its last value.
- CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all held entries (hazard unit clear).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  held beat present for the downstream stage.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  held payload.
- stall_count  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Accept: `in_valid && in_ready` on the clock edge. Release: `out_valid && out_ready` on the clock edge.
- Priority, highest first: rst, flush, normal handshake.
- rst: every valid bit = 0, `out_data` = CLEAR_VALUE, skid entry = CLEAR_VALUE, `stall_count` = 0.
- flush: every valid bit = 0 and `out_data` = CLEAR_VALUE on the next edge. A beat presented in the same cycle is discarded. `stall_count` is unaffected. `in_ready` is not gated by flush.
- Normal handshake, single entry:
  - Load when accepted. The entry empties on release with no simultaneous accept.
  - Accept and release in the same cycle replace the entry: `out_valid` stays 1 and the new data appears.
- Bubble: when the entry empties and BUBBLE_CLEAR=1, `out_data` = CLEAR_VALUE on that edge.
- Stall counter: increments by 1 each cycle with `out_valid && !out_ready && !flush`. It holds at 2^CNT_W−1 and never wraps.
- Payload ordering is strictly FIFO. No beat is duplicated or dropped except by flush.

## Timing
- Latency in_data→out_data is 1 cycle when the stage is empty or draining.
- Without skid:
  - `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
  - Full throughput: 1 beat per cycle.
- With skid:
  - `in_ready = !skid_valid`. This is a register output with no combinational path from `out_ready`.
- Reset values: `out_valid` 0, `out_data` CLEAR_VALUE, `in_ready` 1, `stall_count` 0.
- Reset or flush asserted mid-transfer takes effect on the same edge. Downstream sees `out_valid` = 0 on the following cycle.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined:
  - Adds a second (skid) entry.
  - When main is full, `out_ready` = 0 and a beat is accepted, the beat goes to skid.
  - On release, skid moves to main in the same edge and skid empties.
  - Flush and rst clear both entries.
  - Sustains 1 beat/cycle with a registered `in_ready`.
- Undefined: single entry only, and `in_ready` is the combinational form above.

## Structure
- Shared package `pipe_pkg`:
  - Packed struct typedefs per stage boundary, e.g. `id_ex_payload_t` bundling the control, PC, operand, immediate, opcode and register-index fields.
  - Matching `*_NOP` constants used as CLEAR_VALUE.
  - `PIPE_CNT_W_DEFAULT`.
- Sub-module `pipe_sat_counter` holds the saturating stall counter, parametrised by CNT_W.

## Test plan
- Reset then stream: rst 1 cycle, then in_data 0x11, 0x22, 0x33 on consecutive cycles with `out_ready` = 1 → out_data 0x11, 0x22, 0x33 one cycle later each, `out_valid` continuous, `stall_count` = 0.
- Backpressure: stage holds 0xAA, `out_ready` = 0 for 4 cycles, `in_valid` = 1 with 0xBB → `out_data` stays 0xAA and `stall_count` = 4. Without skid, `in_ready` = 0. With skid, 0xBB is taken into skid and `in_ready` = 0 from the next cycle. After `out_ready` = 1, 0xAA then 0xBB are delivered.
- Flush: entry (and skid) valid, `flush` = 1 with `in_valid` = 1 and in_data 0xCC → next cycle `out_valid` = 0, `out_data` = CLEAR_VALUE (0x00000013 for the ID/EX NOP), and 0xCC never appears.
- Drain bubble: single beat 0x55 released, no new input → with BUBBLE_CLEAR = 1, `out_data` = CLEAR_VALUE. With BUBBLE_CLEAR = 0, `out_data` stays 0x55 and `out_valid` = 0.
- Saturation: CNT_W = 4, `out_ready` = 0 for 20 cycles with a valid entry → `stall_count` reaches 15 and holds.
- Reset mid-stall: `stall_count` = 7 and an entry valid, assert rst → next cycle `stall_count` = 0, `out_valid` = 0, `in_ready` = 1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline definitions. Holds the packed payload struct
//                for each stage boundary and the matching NOP constant that a
//                pipe_stage_reg loads as its CLEAR_VALUE. Also holds the
//                default stall counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default width of the saturating stall counter in each stage register.
    localparam int PIPE_CNT_W_DEFAULT = 16;

    // RV32I canonical NOP: addi x0, x0, 0.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [6:0]  OPC_NOP   = 7'h13;

    // ------------------------------------------------------------------------
    // Control bundle carried from decode towards write-back
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    // All-zero control means no architectural side effect.
    localparam ctrl_t CTRL_NOP = '0;

    // ------------------------------------------------------------------------
    // IF/ID boundary
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    localparam if_id_payload_t IF_ID_NOP = '{
        pc    : 32'h0,
        instr : INSTR_NOP
    };

    // ------------------------------------------------------------------------
    // ID/EX boundary. The opcode sits in the least significant bits so the
    // NOP bundle reads as 0x13 when truncated to a 32-bit payload.
    // ------------------------------------------------------------------------
    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opcode;
    } id_ex_payload_t;

    localparam id_ex_payload_t ID_EX_NOP = '{
        ctrl    : CTRL_NOP,
        pc      : 32'h0,
        rs1_val : 32'h0,
        rs2_val : 32'h0,
        imm     : 32'h0,
        rd      : 5'd0,
        rs1     : 5'd0,
        rs2     : 5'd0,
        opcode  : OPC_NOP
    };

    // ------------------------------------------------------------------------
    // EX/MEM boundary
    // ------------------------------------------------------------------------
    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
    } ex_mem_payload_t;

    localparam ex_mem_payload_t EX_MEM_NOP = '{
        ctrl       : CTRL_NOP,
        alu_result : 32'h0,
        store_data : 32'h0,
        rd         : 5'd0
    };

    // ------------------------------------------------------------------------
    // MEM/WB boundary
    // ------------------------------------------------------------------------
    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] wb_data;
        logic [4:0]  rd;
    } mem_wb_payload_t;

    localparam mem_wb_payload_t MEM_WB_NOP = '{
        ctrl    : CTRL_NOP,
        wb_data : 32'h0,
        rd      : 5'd0
    };

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Handshake bundle around one pipeline stage register.
//                slave  - the stage register itself
//                master - the surrounding pipeline (upstream stage, downstream
//                         stage and hazard unit seen as one driver)
//  Signals     : flush       hazard-unit squash
//                in_valid    upstream beat present
//                in_ready    stage can accept a beat
//                in_data     upstream payload        [DATA_W]
//                out_valid   held beat present
//                out_ready   downstream consumes the beat
//                out_data    held payload            [DATA_W]
//                stall_count saturating stall cycles [CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = PIPE_CNT_W_DEFAULT
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  stall_count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output stall_count
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sat_counter
//  Description : Up-counter that sticks at its all-ones value instead of
//                wrapping.
//  Ports       : clk    clock
//                rst    synchronous active-high reset, clears the count
//                inc    add one on this edge (ignored once saturated)
//                count  current value [CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_cnt_max)) begin
            r_count <= r_count + c_cnt_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Valid/ready pipeline stage register carrying a packed payload
//                between two stages. Flush squashes held beats and loads
//                CLEAR_VALUE; an optional bubble clear restores CLEAR_VALUE
//                whenever the stage drains; a saturating counter records
//                cycles the held beat was blocked downstream.
//  Build option: define PIPE_STAGE_REG_SKID_EN to add a second (skid) entry,
//                which makes in_ready a pure register output. Without it the
//                stage is a single entry and in_ready depends combinationally
//                on out_ready.
//  Ports       : clk  clock
//                rst  synchronous active-high reset
//                bus  pipe_stage_reg_if.slave (flush, in_*, out_*, stall_count)
//  Parameters  : DATA_W       payload width
//                CLEAR_VALUE  NOP/bubble payload
//                BUBBLE_CLEAR 1: out_data returns to CLEAR_VALUE on drain
//                             0: out_data keeps its last value on drain
//                CNT_W        stall counter width
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    parameter bit                BUBBLE_CLEAR = 1'b1,
    parameter int                CNT_W        = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);

    // Main entry: this is what the downstream stage sees.
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_release;
    logic              w_stall;
    logic [DATA_W-1:0] w_empty_data;

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_release = r_main_valid & bus.out_ready;

    // Payload left on out_data when the main entry empties without refill.
    generate
        if (BUBBLE_CLEAR) begin : g_bubble_clear
            assign w_empty_data = CLEAR_VALUE;
        end else begin : g_bubble_hold
            assign w_empty_data = r_main_data;
        end
    endgenerate

`ifdef PIPE_STAGE_REG_SKID_EN
    // Skid entry catches the beat accepted while main is blocked, so the
    // upstream can be told "ready" one cycle ahead from a flop.
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    assign w_in_ready = ~r_skid_valid;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= CLEAR_VALUE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= CLEAR_VALUE;
        end else if (!r_main_valid) begin
            // Skid is never occupied while main is empty.
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= bus.in_data;
            end
        end else if (w_release) begin
            if (r_skid_valid) begin
                // Oldest waiting beat moves up; in_ready was low, so no
                // new beat can arrive on this edge.
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_data  <= CLEAR_VALUE;
            end else if (w_accept) begin
                r_main_data  <= bus.in_data;
            end else begin
                r_main_valid <= 1'b0;
                r_main_data  <= w_empty_data;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= bus.in_data;
        end
    end
`else
    // Single entry: a held beat may be replaced in the same cycle it leaves.
    assign w_in_ready = ~r_main_valid | bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= CLEAR_VALUE;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_data  <= bus.in_data;
        end else if (w_release) begin
            r_main_valid <= 1'b0;
            r_main_data  <= w_empty_data;
        end
    end
`endif

    // A flushed cycle is not a stall: the held beat is discarded instead.
    assign w_stall = r_main_valid & ~bus.out_ready & ~bus.flush;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (bus.stall_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. Two instances share
//                one stimulus stream: dut1 with BUBBLE_CLEAR=1, dut0 with
//                BUBBLE_CLEAR=0. A queue-based model of the held beats
//                predicts every output each cycle; directed sequences pin
//                literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int          DW  = 32;
    localparam int          CW  = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;  // ID/EX NOP on a 32-bit payload
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_flush = 1'b0;
    logic          tb_in_valid = 1'b0;
    logic          tb_out_ready = 1'b0;
    logic [DW-1:0] tb_in_data = '0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus0 ();

    assign bus1.flush     = tb_flush;
    assign bus1.in_valid  = tb_in_valid;
    assign bus1.in_data   = tb_in_data;
    assign bus1.out_ready = tb_out_ready;
    assign bus0.flush     = tb_flush;
    assign bus0.in_valid  = tb_in_valid;
    assign bus0.in_data   = tb_in_data;
    assign bus0.out_ready = tb_out_ready;

    pipe_stage_reg #(.DATA_W(DW), .CLEAR_VALUE(NOP), .BUBBLE_CLEAR(1'b1), .CNT_W(CW))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipe_stage_reg #(.DATA_W(DW), .CLEAR_VALUE(NOP), .BUBBLE_CLEAR(1'b0), .CNT_W(CW))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the stage is a FIFO of held beats with capacity 1
    // (or 2 with the skid entry). Head of the queue is what is shown.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_q[$];
    int            m_cnt  = 0;
    logic [DW-1:0] m_hold = NOP;   // out_data shown when empty and not clearing
    bit            m_acc;
    bit            m_rel;

    function automatic bit exp_in_ready(input int occupancy, input bit ordy);
        if (SKID) return occupancy < 2;
        return (occupancy == 0) || ordy;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt  = 0;
            m_hold = NOP;
        end else begin
            if (m_q.size() > 0 && !tb_out_ready && !tb_flush && m_cnt < CNT_MAX)
                m_cnt = m_cnt + 1;
            if (tb_flush) begin
                m_q.delete();
                m_hold = NOP;
            end else begin
                m_acc = tb_in_valid && exp_in_ready(m_q.size(), tb_out_ready);
                m_rel = (m_q.size() > 0) && tb_out_ready;
                if (m_rel) void'(m_q.pop_front());
                if (m_acc) m_q.push_back(tb_in_data);
                if (m_q.size() > 0) m_hold = m_q[0];
            end
        end
    end

    // Per-cycle compare, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready1",  bus1.in_ready,  exp_in_ready(m_q.size(), tb_out_ready));
            check("in_ready0",  bus0.in_ready,  exp_in_ready(m_q.size(), tb_out_ready));
            check("out_valid1", bus1.out_valid, m_q.size() > 0);
            check("out_valid0", bus0.out_valid, m_q.size() > 0);
            check("out_data1",  bus1.out_data,  (m_q.size() > 0) ? m_q[0] : NOP);
            check("out_data0",  bus0.out_data,  (m_q.size() > 0) ? m_q[0] : m_hold);
            check("stall1",     32'(bus1.stall_count), m_cnt);
            check("stall0",     32'(bus0.stall_count), m_cnt);
        end
    end

    task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] d, input bit ordy);
        rst          = r;
        tb_flush     = f;
        tb_in_valid  = iv;
        tb_in_data   = d;
        tb_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_valid",  bus1.out_valid, 0);
        check("rst_data1",  bus1.out_data, NOP);
        check("rst_data0",  bus0.out_data, NOP);
        check("rst_ready",  bus1.in_ready, 1);
        check("rst_stall",  32'(bus1.stall_count), 0);

        // Stream
        drive(0, 0, 1, 32'h11, 1);
        check("s1_data",  bus1.out_data, 32'h11);
        check("s1_valid", bus1.out_valid, 1);
        drive(0, 0, 1, 32'h22, 1);
        check("s2_data",  bus1.out_data, 32'h22);
        check("s2_valid", bus1.out_valid, 1);
        drive(0, 0, 1, 32'h33, 1);
        check("s3_data",  bus1.out_data, 32'h33);
        check("s3_stall", 32'(bus1.stall_count), 0);

        // Backpressure
        drive(0, 0, 1, 32'hAA, 1);
        check("bp_load", bus1.out_data, 32'hAA);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'hBB, 0);
        check("bp_hold",    bus1.out_data, 32'hAA);
        check("bp_stall",   32'(bus1.stall_count), 4);
        check("bp_ready",   bus1.in_ready, 0);
        check("model_bp",   m_cnt, 4);
        drive(0, 0, !SKID, 32'hBB, 1);
        check("bp_next",    bus1.out_data, 32'hBB);
        check("bp_nvalid",  bus1.out_valid, 1);
        drive(0, 0, 0, 0, 1);
        check("bp_empty",   bus1.out_valid, 0);
        check("bp_bub1",    bus1.out_data, NOP);
        check("bp_bub0",    bus0.out_data, 32'hBB);

        // Flush with a beat presented in the same cycle
        drive(0, 0, 1, 32'h21, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(0, 1, 1, 32'hCC, 0);
        check("fl_valid", bus1.out_valid, 0);
        check("fl_data1", bus1.out_data, NOP);
        check("fl_data0", bus0.out_data, NOP);
        check("fl_stall", 32'(bus1.stall_count), 5);
        drive(0, 0, 0, 0, 1);
        check("fl_after", bus1.out_valid, 0);
        check("fl_nocc",  bus0.out_data, NOP);

        // Drain bubble
        drive(0, 0, 1, 32'h55, 1);
        check("dr_load", bus1.out_data, 32'h55);
        drive(0, 0, 0, 0, 1);
        check("dr_valid", bus0.out_valid, 0);
        check("dr_bub1",  bus1.out_data, NOP);
        check("dr_bub0",  bus0.out_data, 32'h55);

        // Reset mid-stall
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h77, 1);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0);
        check("ms_stall", 32'(bus1.stall_count), 7);
        drive(1, 0, 0, 0, 0);
        check("ms_cnt",   32'(bus1.stall_count), 0);
        check("ms_valid", bus1.out_valid, 0);
        check("ms_ready", bus1.in_ready, 1);

        // Saturation
        drive(0, 0, 1, 32'h66, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);
        check("sat_cnt",   32'(bus1.stall_count), 15);
        check("sat_data",  bus1.out_data, 32'h66);
        check("model_sat", m_cnt, 15);
        drive(0, 0, 0, 0, 1);
        check("sat_hold",  32'(bus1.stall_count), 15);
        check("sat_empty", bus1.out_valid, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0,
                  $urandom_range(15) == 0,
                  $urandom_range(1) == 1,
                  $urandom,
                  $urandom_range(4) < 3);
        end
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
